// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one pipelined ALU among NUM_REQ requesters
// Optional grant counter enabled by defining ALU_ARB_PERF_CNT_EN.
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 128,
    parameter int ALU_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [4*NUM_REQ-1:0]     req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0] req_input1,
    input  logic [WIDTH*NUM_REQ-1:0] req_input2,
    input  logic [5*NUM_REQ-1:0]     req_shift,
    output logic [3:0]               alu_opcode,
    output logic [WIDTH-1:0]         alu_input1,
    output logic [WIDTH-1:0]         alu_input2,
    output logic [4:0]               alu_shift,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    input  logic                     alu_sign,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic                     rsp_sign,
    output logic                     rsp_err,
    output logic [31:0]              perf_grants
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               accept;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_in1;
    logic [WIDTH-1:0]   sel_in2;
    logic [4:0]         sel_sh;
    logic               sel_err;

    logic [ALU_LAT-1:0] tag_valid;
    logic [ALU_LAT-1:0] tag_err;
    logic [NUM_REQ-1:0] tag_owner [ALU_LAT];

    // First valid requester at or after ptr, wrapping past the top index.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        if (arb_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!found && (j == (int'(ptr) + k) % NUM_REQ) && req_valid[j]) begin
                        grant[j] = 1'b1;
                        gidx     = IDX_W'(j);
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_op  = '0;
        sel_in1 = '0;
        sel_in2 = '0;
        sel_sh  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                sel_op  = req_opcode[4*j +: 4];
                sel_in1 = req_input1[WIDTH*j +: WIDTH];
                sel_in2 = req_input2[WIDTH*j +: WIDTH];
                sel_sh  = req_shift[5*j +: 5];
            end
        end
    end

    assign sel_err   = (sel_op > 4'd8) || ((sel_op == 4'd6) && (sel_in2 == '0));
    assign req_ready = grant;
    assign accept    = |grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            alu_opcode <= 4'hF;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_shift  <= '0;
        end else if (accept) begin
            ptr        <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            alu_opcode <= sel_op;
            alu_input1 <= sel_in1;
            alu_input2 <= sel_in2;
            alu_shift  <= sel_sh;
        end else begin
            alu_opcode <= 4'hF;
        end
    end

    // Tag pipeline tracks each issued op alongside the ALU; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_err   <= '0;
            for (int s = 0; s < ALU_LAT; s++) tag_owner[s] <= '0;
        end else begin
            tag_valid[0] <= accept;
            tag_err[0]   <= sel_err;
            tag_owner[0] <= grant;
            for (int s = 1; s < ALU_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_err[s]   <= tag_err[s-1];
                tag_owner[s] <= tag_owner[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (tag_valid[ALU_LAT-1]) begin
            rsp_valid  <= tag_owner[ALU_LAT-1];
            rsp_err    <= tag_err[ALU_LAT-1];
            rsp_result <= tag_err[ALU_LAT-1] ? '0 : alu_result;
            rsp_carry  <= alu_carry & ~tag_err[ALU_LAT-1];
            rsp_zero   <= alu_zero  & ~tag_err[ALU_LAT-1];
            rsp_sign   <= alu_sign  & ~tag_err[ALU_LAT-1];
        end else begin
            rsp_valid  <= '0;
        end
    end

`ifdef ALU_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grants <= '0;
        end else if (accept && (perf_grants != 32'hFFFF_FFFF)) begin
            perf_grants <= perf_grants + 32'd1;
        end
    end
`else
    assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - randomized self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;
    localparam int N = 4;
    localparam int W = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             arb_en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [4*N-1:0]   req_opcode;
    logic [W*N-1:0]   req_input1;
    logic [W*N-1:0]   req_input2;
    logic [5*N-1:0]   req_shift;
    logic [3:0]       alu_opcode;
    logic [W-1:0]     alu_input1;
    logic [W-1:0]     alu_input2;
    logic [4:0]       alu_shift;
    logic [W-1:0]     alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_sign;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_sign;
    logic             rsp_err;
    logic [31:0]      perf_grants;

    always #5 clk = ~clk;

    alu_req_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LAT(2)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_input1(req_input1), .req_input2(req_input2),
        .req_shift(req_shift),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shift(alu_shift),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
        .perf_grants(perf_grants)
    );

    // Returns {carry, result}; undefined opcodes yield nonzero junk.
    function automatic logic [W:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] r;
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {(a < b), a - b};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, a << sh};
            4'd6: begin r = (b == '0) ? '1 : a / b; return {1'b0, r}; end
            4'd7: return {1'b0, a >> sh};
            4'd8: begin r = a * b; return {1'b0, r}; end
            default: return {1'b1, a ^ ~b};
        endcase
    endfunction

    // ALU stand-in: ALU_LAT=2 means one register stage after the alu_* registers.
    logic [W:0] alu_q;
    always @(posedge clk) alu_q <= alu_fn(alu_opcode, alu_input1, alu_input2, alu_shift);
    assign alu_result = alu_q[W-1:0];
    assign alu_carry  = alu_q[W];
    assign alu_zero   = (alu_q[W-1:0] == '0);
    assign alu_sign   = alu_q[W-1];

    typedef struct {
        int           due;
        int           owner;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } exp_t;

    exp_t         exp_q[$];
    int           m_ptr;
    int           cyc;
    int unsigned  m_perf;
    logic [W-1:0] last_res;
    logic [3:0]   last_fl;
    int           checks;
    int           errors;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_perf();
`ifdef ALU_ARB_PERF_CNT_EN
        return m_perf;
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
        req_valid[i]          = v;
        req_opcode[4*i +: 4]  = op;
        req_input1[W*i +: W]  = a;
        req_input2[W*i +: W]  = b;
        req_shift[5*i +: 5]   = sh;
    endtask

    task automatic clear_reqs();
        req_valid  = '0;
        req_opcode = '0;
        req_input1 = '0;
        req_input2 = '0;
        req_shift  = '0;
    endtask

    // Entered just after a negedge with inputs set; leaves at the next negedge.
    task automatic step();
        int           g;
        int           idx;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_valid;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W:0]   r;
        logic         err;
        exp_t         e;
        #1;
        g = -1;
        if (arb_en) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", W'(req_ready), W'(exp_ready));
        if (g >= 0) begin
            op  = req_opcode[4*g +: 4];
            a   = req_input1[W*g +: W];
            b   = req_input2[W*g +: W];
            r   = alu_fn(op, a, b, req_shift[5*g +: 5]);
            err = (op > 4'd8) || (op == 4'd6 && b == '0);
            e.due   = cyc + 3;
            e.owner = g;
            e.res   = err ? '0 : r[W-1:0];
            e.fl    = err ? 4'b0001 : {r[W], (r[W-1:0] == '0), r[W-1], 1'b0};
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_perf++;
        end
        #1;
        exp_valid = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_valid[e.owner] = 1'b1;
            last_res = e.res;
            last_fl  = e.fl;
        end
        check_eq("rsp_valid", W'(rsp_valid), W'(exp_valid));
        check_eq("rsp_result", rsp_result, last_res);
        check_eq("rsp_flags", W'({rsp_carry, rsp_zero, rsp_sign, rsp_err}), W'(last_fl));
        check_eq("perf_grants", W'(perf_grants), W'(exp_perf()));
        @(negedge clk);
    endtask

    // Entered at a negedge; asserts rst across one posedge.
    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        #1;
        exp_q.delete();
        m_ptr    = 0;
        m_perf   = 0;
        last_res = '0;
        last_fl  = '0;
        check_eq("rst_rsp_valid", W'(rsp_valid), '0);
        check_eq("rst_rsp_result", rsp_result, '0);
        check_eq("rst_alu_opcode", W'(alu_opcode), W'(4'hF));
        check_eq("rst_alu_input1", alu_input1, '0);
        check_eq("rst_perf", W'(perf_grants), '0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        arb_en = 1'b1;
        clear_reqs();
        @(negedge clk);
        do_reset();
        idle(2);

        // All four requesting for 4 cycles: grants rotate 0,1,2,3.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(i), W'(i + 5), W'(3), 5'd1);
        for (int c = 0; c < 4; c++) step();
        idle(5);

        // Full-width ADD overflow on requester 2.
        set_req(2, 1'b1, 4'd0, '1, W'(1), 5'd0);
        step();
        idle(4);

        // DIV by zero on requester 1, illegal opcode on requester 3.
        set_req(1, 1'b1, 4'd6, W'(10), '0, 5'd0);
        set_req(3, 1'b1, 4'd12, W'(7), W'(9), 5'd0);
        step();
        step();
        idle(4);

        // Grants held off while arb_en is low, then resume at the pointer.
        arb_en = 1'b0;
        set_req(0, 1'b1, 4'd3, W'(1), W'(2), 5'd0);
        set_req(1, 1'b1, 4'd4, W'(5), W'(6), 5'd0);
        for (int c = 0; c < 5; c++) step();
        arb_en = 1'b1;
        step();
        step();
        idle(4);

        // Reset with an op in flight: it must never respond; grant restarts at 0.
        set_req(1, 1'b1, 4'd0, W'(8), W'(8), 5'd0);
        step();
        set_req(1, 1'b0, 4'd0, '0, '0, 5'd0);
        set_req(0, 1'b1, 4'd0, W'(1), W'(1), 5'd0);
        step();
        do_reset();
        idle(5);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd2, W'(12), W'(10), 5'd0);
        #1;
        check_eq("first_grant_after_rst", W'(req_ready), W'(4'b0001));
        step();
        idle(4);

        // Five accepts after a fresh reset.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clear_reqs();
            set_req(i % N, 1'b1, 4'd0, W'(i), W'(i), 5'd0);
            step();
        end
        idle(4);
`ifdef ALU_ARB_PERF_CNT_EN
        check_eq("perf_after_5", W'(perf_grants), W'(5));
`else
        check_eq("perf_after_5", W'(perf_grants), W'(0));
`endif

        // Randomized traffic, including arb_en drops with ops in flight.
        for (int c = 0; c < 400; c++) begin
            arb_en = (($urandom % 8) != 0);
            for (int i = 0; i < N; i++) begin
                set_req(i, 1'($urandom % 2), 4'($urandom_range(0, 15)),
                        {$urandom, $urandom, $urandom, $urandom},
                        (($urandom % 6) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom},
                        5'($urandom));
            end
            step();
        end
        arb_en = 1'b1;
        idle(5);
        check_eq("drained", W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
